// File: rtl/vga_line_fetch_ctrl_if.sv
// Memory read port and line-buffer write port of the VGA line fetcher.
// master = fetch controller, slave = memory / line-buffer side.
interface vga_line_fetch_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int LB_AW  = 8
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic              lb_we;
    logic              lb_bank;
    logic [LB_AW-1:0]  lb_waddr;
    logic [DATA_W-1:0] lb_wdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_data,
        output lb_we, lb_bank, lb_waddr, lb_wdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_data,
        input  lb_we, lb_bank, lb_waddr, lb_wdata
    );
endinterface

// File: rtl/vga_line_fetch_ctrl.sv
// Ping-pong line fetcher: while line v is displayed, line v+1 is read into the other bank.
// Optional macro UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter output.
//
// state | meaning
// IDLE  | waiting for cnt_h==0 trigger
// REQ   | mem_req high, waiting for mem_ack
// WR    | writing captured word to the line buffer
module vga_line_fetch_ctrl #(
    parameter int H_TOTAL        = 800,
    parameter int V_TOTAL        = 525,
    parameter int V_ACTIVE       = 480,
    parameter int WORDS_PER_LINE = 160,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 17,
    parameter int BASE_ADDR      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] cnt_h,
    input  logic [9:0] cnt_v,
    vga_line_fetch_ctrl_if.master bus,
    output logic       fetch_busy,
    output logic       line_done,
    output logic       underrun
`ifdef UNDERRUN_CNT_EN
    ,output logic [15:0] underrun_count
`endif
);
    localparam int          LB_AW  = $clog2(WORDS_PER_LINE);
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [LB_AW-1:0] W_LAST = LB_AW'(WORDS_PER_LINE - 1);
    localparam logic [31:0] WPL32  = 32'(WORDS_PER_LINE);
    localparam logic [31:0] BASE32 = 32'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, REQ, WR} state_t;

    state_t              state_q, state_d;
    logic [LB_AW-1:0]    word_q;
    logic [DATA_W-1:0]   data_q;
    logic                bank_q;
    logic [ADDR_W-1:0]   line_base_q;

    logic [9:0]          tgt;
    logic [31:0]         line_calc;
    logic [ADDR_W-1:0]   addr_cur;
    logic                trig;
    logic                deadline;
    logic                last_word;
    logic                load;
    logic                capture;
    logic                advance;

    // Line after the last line of the frame wraps to line 0.
    assign tgt       = (cnt_v == V_LAST) ? 10'd0 : cnt_v + 10'd1;
    assign line_calc = BASE32 + 32'(tgt) * WPL32;
    assign trig      = (state_q == IDLE) && enable && (cnt_h == 10'd0) && (tgt < V_ACT);
    assign deadline  = (cnt_h == H_LAST);
    assign last_word = (word_q == W_LAST);
    assign addr_cur  = line_base_q + ADDR_W'(word_q);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = REQ;
                    load    = 1'b1;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_d = WR;
                    capture = 1'b1;
                end
            end
            WR: begin
                if (last_word) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQ;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Deadline abort wins over everything; a late ack is dropped.
        if (deadline && state_q != IDLE) begin
            state_d = IDLE;
            capture = 1'b0;
            advance = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            data_q      <= '0;
            bank_q      <= 1'b0;
            line_base_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                word_q      <= '0;
                bank_q      <= tgt[0];
                line_base_q <= ADDR_W'(line_calc);
            end
            if (capture) data_q <= bus.mem_data;
            if (advance) word_q <= word_q + LB_AW'(1);
        end
    end

    assign bus.mem_req  = (state_q == REQ);
    assign bus.mem_addr = (state_q == REQ) ? addr_cur : '0;
    assign bus.lb_we    = (state_q == WR);
    assign bus.lb_bank  = bank_q;
    assign bus.lb_waddr = word_q;
    assign bus.lb_wdata = data_q;

    assign fetch_busy = (state_q != IDLE);
    assign line_done  = (state_q == WR) && last_word;
    assign underrun   = deadline && (state_q != IDLE);

`ifdef UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (underrun && underrun_count != 16'hFFFF) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif
endmodule
